// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step-counter width; at least one bit so WIDTH=2 still has a counter.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: shifted multiplicand, multiplier shift register and accumulator.
// load captures operand magnitudes and clears acc; step retires one multiplier bit.
module mult_shift_add_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_sh;

    // Sum including the current bit, so the FSM can capture the final product on the last step.
    assign acc_next = b_sh[0] ? (acc + a_sh) : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
        end else if (load) begin
            a_sh <= {{WIDTH{1'b0}}, a_mag};
            b_sh <= b_mag;
            acc  <= '0;
        end else if (step) begin
            acc  <= acc_next;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
        end
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 sequential multiplier with valid/ready handshakes on operands and product.
// Define MULT_SIGNED_EN for two's-complement operands and product.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for an operand pair
//   CALC  | one multiplier bit retired per clock, WIDTH clocks total
//   DONE  | out_valid=1, product held until out_ready
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               step;
    logic               last_step;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] result;

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULT_SIGNED_EN
    logic sign;

    // Magnitude of the most-negative value still fits WIDTH bits as unsigned.
    assign a_mag  = a[WIDTH-1] ? -a : a;
    assign b_mag  = b[WIDTH-1] ? -b : b;
    assign result = sign ? -acc_next : acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sign <= 1'b0;
        end else if (load) begin
            sign <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign result = acc_next;
`endif

    mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == CALC) || (state == DONE);
        load      = (state == IDLE) && in_valid;
        step      = (state == CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            product <= '0;
        end else begin
            if (load) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (step && last_step) begin
                product <= result;
            end
        end
    end

endmodule
